ram_tx_sequencer: RTL and testbench
===================================

Name: ram_tx_sequencer

Overview:
Transmit-side controller that sequences the 256x16 word RAM into the bit serializer. On a send request it walks RAM addresses 0..N-1 and reads each word when the serial-receive writer does not own the RAM. It hands each word to the serializer with a start/busy handshake and signals completion. It sits between the RAM read port, the receive/write controller (as RAM owner) and the serializer.

Parameters:
ADDR_W, 8, RAM address width; max frame is 2^ADDR_W words
DATA_W, 16, RAM word and serializer data width
RAM_LAT, 1, RAM read latency in cycles from rd_en to valid rd_data (1 or 2)

Ports:
sysclk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset
send  in  1  transmit request, level; rising edge starts a frame
word_count  in  ADDR_W+1  number of words to send, sampled at start (0..2^ADDR_W)
wr_active  in  1  writer owns RAM this cycle; sequencer must not read
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  RAM read address
rd_data  in  DATA_W  RAM read data, valid RAM_LAT cycles after rd_en
ser_data  out  DATA_W  word presented to serializer, held stable while serializer busy
ser_start  out  1  one-cycle load pulse to serializer
ser_busy  in  1  serializer shifting
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (reset=0, async): state IDLE; rd_en=0, rd_addr=0, ser_data=0, ser_start=0, busy=0, done=0; send edge register cleared, so a send held high through reset release does not start a frame.
- Send detect: start = send & ~send_q. Ignored unless in IDLE; no queuing.
- States: IDLE, LATCH, READ, WAIT_DATA, LOAD, WAIT_BUSY, WAIT_IDLE, NEXT, FINISH.
- IDLE->LATCH on start. LATCH captures word_count into cnt and clears addr and idx; busy=1 from LATCH onward.
- LATCH: cnt==0 -> FINISH (no reads, no ser_start); else -> READ.
- READ: if wr_active=0, assert rd_en for exactly one cycle with rd_addr=idx, then -> WAIT_DATA. If wr_active=1, rd_en stays 0 and the state holds. The writer always has priority; rd_en and wr_active are never both 1.
- WAIT_DATA: count RAM_LAT cycles, capture rd_data into ser_data on the last one -> LOAD.
- LOAD: ser_start=1 for one cycle -> WAIT_BUSY.
- WAIT_BUSY: wait for ser_busy=1 -> WAIT_IDLE. There is no timeout.
- WAIT_IDLE: wait for ser_busy=0 -> NEXT.
- NEXT: idx+1. If idx+1==cnt -> FINISH, else -> READ. idx is ADDR_W+1 bits, so cnt=256 reaches address 255 with no wrap.
- FINISH: done=1 for one cycle, busy=0 next cycle, -> IDLE.
- Latency: with wr_active=0 and RAM_LAT=1, the first ser_start is 3 cycles after the send edge is registered.
- word_count changes mid-frame are ignored.
- ser_data holds the last word after the frame ends.

Optional Feature:
Macro SEQ_CHECKSUM_EN.
- Defined: a DATA_W accumulator (mod 2^DATA_W sum) clears in LATCH and adds each captured word. After the last data word, an extra LOAD/WAIT_BUSY/WAIT_IDLE pass sends the sum, then FINISH. cnt==0 sends a single word 0x0000.
- Undefined: no accumulator and no extra word; behaviour exactly as above.

Decomposition:
- Package tx_seq_pkg holds:
  - state enum
  - ADDR_W/DATA_W defaults
  - RAM_LAT limits
- One sub-module, rise_detect (registered edge detector with async active-low reset), used for send.

Test Plan:
- RAM preloaded 0x1111,0x2222,0x3333; word_count=3; send pulse; serializer model busy 20 cycles -> three ser_start pulses with ser_data 0x1111,0x2222,0x3333 in order; rd_addr 0,1,2; one done pulse; busy low afterwards.
- word_count=0, send -> done pulse 2 cycles after the edge; no rd_en, no ser_start.
- wr_active held high 10 cycles while in READ -> rd_en stays 0 throughout; read issues on the first cycle wr_active=0; never overlaps.
- word_count=256, RAM[i]=i -> 256 words sent, last rd_addr=255, no address wrap, single done pulse.
- reset asserted mid-frame during WAIT_IDLE -> all outputs 0 immediately; a new send after release restarts at address 0.
- SEQ_CHECKSUM_EN with words 0xFFFF,0x0002 -> third word 0x0001, then done.

Source files
------------

// File: rtl/tx_seq_pkg.sv
// Purpose: shared types and defaults for the RAM-to-serializer transmit sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tx_seq_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_READ,
        S_WAIT_DATA,
        S_LOAD,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_NEXT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/ram_tx_sequencer_rise_detect.sv
// Purpose: registered rising-edge detector; a level already high at reset release is not an edge.
// Latency: rise is combinational from d, qualified by one cycle of history.
// Backpressure: none.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic primed;

    // Track previous level; primed stays low for the first cycle after reset so a held level is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= 1'b0;
            primed <= 1'b0;
        end else begin
            d_q    <= d;
            primed <= 1'b1;
        end
    end

    assign rise = primed & d & ~d_q;

endmodule

// File: rtl/ram_tx_sequencer.sv
// Purpose: walk RAM words 0..N-1 into the bit serializer (optional trailing sum word: SEQ_CHECKSUM_EN).
// Latency: first ser_start 3 cycles after the registered send edge (wr_active=0, RAM_LAT=1).
// Backpressure: reads stall while wr_active; each word waits for ser_busy to rise then fall.
module ram_tx_sequencer
    import tx_seq_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RAM_LAT = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              send,
    input  logic [ADDR_W:0]   word_count,
    input  logic              wr_active,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] ser_data,
    output logic              ser_start,
    input  logic              ser_busy,
    output logic              busy,
    output logic              done
);

    // Read latency clamped to what the wait counter supports.
    localparam int LAT = (RAM_LAT < RAM_LAT_MIN) ? RAM_LAT_MIN :
                         (RAM_LAT > RAM_LAT_MAX) ? RAM_LAT_MAX : RAM_LAT;

    state_t            state;
    state_t            state_nxt;
    logic              start;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_inc;
    logic [1:0]        lat_cnt;
    logic              lat_last;
`ifdef SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
    logic              sum_phase;
`endif

    rise_detect u_send_edge (
        .clk   (sysclk),
        .rst_n (reset),
        .d     (send),
        .rise  (start)
    );

    assign idx_inc  = idx + (ADDR_W+1)'(1);
    assign lat_last = (lat_cnt == 2'(LAT - 1));

    // State register.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; the writer always wins the RAM in READ.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_LATCH;
`ifdef SEQ_CHECKSUM_EN
            S_LATCH:     state_nxt = (word_count == '0) ? S_LOAD : S_READ;
`else
            S_LATCH:     state_nxt = (word_count == '0) ? S_FINISH : S_READ;
`endif
            S_READ:      if (!wr_active) state_nxt = S_WAIT_DATA;
            S_WAIT_DATA: if (lat_last) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: if (ser_busy) state_nxt = S_WAIT_IDLE;
`ifdef SEQ_CHECKSUM_EN
            S_WAIT_IDLE: if (!ser_busy) state_nxt = sum_phase ? S_FINISH : S_NEXT;
            S_NEXT:      state_nxt = (idx_inc == cnt) ? S_LOAD : S_READ;
`else
            S_WAIT_IDLE: if (!ser_busy) state_nxt = S_NEXT;
            S_NEXT:      state_nxt = (idx_inc == cnt) ? S_FINISH : S_READ;
`endif
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Frame datapath: count/index capture, latency counter, word capture (and running sum).
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            idx       <= '0;
            lat_cnt   <= '0;
            ser_data  <= '0;
`ifdef SEQ_CHECKSUM_EN
            acc       <= '0;
            sum_phase <= 1'b0;
`endif
        end else begin
            case (state)
                S_LATCH: begin
                    cnt <= word_count;
                    idx <= '0;
`ifdef SEQ_CHECKSUM_EN
                    acc       <= '0;
                    sum_phase <= (word_count == '0);
                    if (word_count == '0) ser_data <= '0;
`endif
                end
                S_READ: lat_cnt <= '0;
                S_WAIT_DATA: begin
                    if (lat_last) begin
                        ser_data <= rd_data;
`ifdef SEQ_CHECKSUM_EN
                        acc      <= acc + rd_data;
`endif
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                S_NEXT: begin
                    idx <= idx_inc;
`ifdef SEQ_CHECKSUM_EN
                    if (idx_inc == cnt) begin
                        ser_data  <= acc;
                        sum_phase <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign rd_en     = (state == S_READ) && !wr_active;
    assign rd_addr   = idx[ADDR_W-1:0];
    assign ser_start = (state == S_LOAD);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH);

endmodule

// File: tb/tb_ram_tx_sequencer.sv
// Purpose: directed checks of the RAM transmit sequencer against a RAM and serializer model.
// Latency: n/a.
// Backpressure: serializer model holds ser_busy for ser_len cycles per load.
module tb_ram_tx_sequencer;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          sysclk = 1'b0;
    logic          reset = 1'b0;
    logic          send = 1'b0;
    logic          wr_active = 1'b0;
    logic [AW:0]   word_count = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] ser_data;
    logic          ser_start;
    logic          ser_busy;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [256];
    int            ser_len = 20;
    int            ser_cnt = 0;
    int            cyc = 0;

    int            total = 0;
    int            bad = 0;

    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_ser[$];
    int            q_start_cyc[$];
    int            q_done_cyc[$];
    int            n_done = 0;
    int            n_overlap = 0;

    always #5 sysclk = ~sysclk;

    ram_tx_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .send       (send),
        .word_count (word_count),
        .wr_active  (wr_active),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .ser_data   (ser_data),
        .ser_start  (ser_start),
        .ser_busy   (ser_busy),
        .busy       (busy),
        .done       (done)
    );

    // RAM model, one cycle read latency.
    always @(posedge sysclk) if (rd_en) rd_data <= mem[rd_addr];

    // Serializer model: busy for ser_len cycles after each load.
    always @(posedge sysclk or negedge reset) begin
        if (!reset)          ser_cnt <= 0;
        else if (ser_start)  ser_cnt <= ser_len;
        else if (ser_cnt > 0) ser_cnt <= ser_cnt - 1;
    end
    assign ser_busy = (ser_cnt != 0);

    always @(posedge sysclk) cyc <= cyc + 1;

    // Monitor, sampled on the falling edge.
    always @(negedge sysclk) begin
        if (rd_en) q_addr.push_back(rd_addr);
        if (ser_start) begin
            q_ser.push_back(ser_data);
            q_start_cyc.push_back(cyc);
        end
        if (done) begin
            n_done = n_done + 1;
            q_done_cyc.push_back(cyc);
        end
        if (rd_en && wr_active) n_overlap = n_overlap + 1;
    end

    task automatic send_frame(input int wc, output int t0);
        @(posedge sysclk); #1;
        word_count = (AW+1)'(wc);
        send = 1'b1;
        t0 = cyc;
        @(posedge sysclk); #1;
        send = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge sysclk);
            if (n_done > base) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int ba;
        reset = 1'b0;
        send = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        total++; if (rd_en !== 1'b0)    begin bad++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
        total++; if (rd_addr !== '0)    begin bad++; $display("FAIL reset_rd_addr got %h want 0", rd_addr); end
        total++; if (ser_data !== '0)   begin bad++; $display("FAIL reset_ser_data got %h want 0", ser_data); end
        total++; if (ser_start !== 1'b0) begin bad++; $display("FAIL reset_ser_start got %b want 0", ser_start); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got %b want 0", done); end
        ba = q_addr.size();
        @(posedge sysclk); #1;
        reset = 1'b1;
        repeat (6) @(negedge sysclk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_send_busy got %b want 0", busy); end
        total++; if (q_addr.size() != ba) begin bad++; $display("FAIL held_send_reads got %0d want 0", q_addr.size() - ba); end
        send = 1'b0;
        repeat (2) @(posedge sysclk);
    endtask

    task automatic test_basic;
        int ba, bs, bd, t0;
        bit to;
        logic [DW-1:0] exp_w [3];
        exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333;
        for (int i = 0; i < 3; i++) mem[i] = exp_w[i];
        ser_len = 20;
        ba = q_addr.size(); bs = q_ser.size(); bd = n_done;
        send_frame(3, t0);
        wait_done(bd, 400, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got timeout want done"); end
        repeat (2) @(negedge sysclk);
        total++; if (q_start_cyc[bs] - t0 != 4) begin bad++; $display("FAIL basic_latency got %0d want 4", q_start_cyc[bs] - t0); end
        total++; if (q_addr.size() - ba != 3) begin bad++; $display("FAIL basic_reads got %0d want 3", q_addr.size() - ba); end
        for (int i = 0; i < 3; i++) begin
            total++; if (q_addr[ba+i] !== AW'(i)) begin bad++; $display("FAIL basic_addr%0d got %h want %h", i, q_addr[ba+i], i); end
            total++; if (q_ser[bs+i] !== exp_w[i]) begin bad++; $display("FAIL basic_word%0d got %h want %h", i, q_ser[bs+i], exp_w[i]); end
        end
`ifdef SEQ_CHECKSUM_EN
        total++; if (q_ser.size() - bs != 4) begin bad++; $display("FAIL basic_words got %0d want 4", q_ser.size() - bs); end
        total++; if (q_ser[bs+3] !== 16'h6666) begin bad++; $display("FAIL basic_sum got %h want 6666", q_ser[bs+3]); end
        total++; if (ser_data !== 16'h6666) begin bad++; $display("FAIL basic_hold got %h want 6666", ser_data); end
`else
        total++; if (q_ser.size() - bs != 3) begin bad++; $display("FAIL basic_words got %0d want 3", q_ser.size() - bs); end
        total++; if (ser_data !== 16'h3333) begin bad++; $display("FAIL basic_hold got %h want 3333", ser_data); end
`endif
        total++; if (n_done - bd != 1) begin bad++; $display("FAIL basic_done got %0d want 1", n_done - bd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_zero;
        int ba, bs, bd, t0;
        bit to;
        ser_len = 5;
        ba = q_addr.size(); bs = q_ser.size(); bd = n_done;
        send_frame(0, t0);
        wait_done(bd, 60, to);
        total++; if (to) begin bad++; $display("FAIL zero_timeout got timeout want done"); end
        repeat (2) @(negedge sysclk);
        total++; if (q_addr.size() != ba) begin bad++; $display("FAIL zero_reads got %0d want 0", q_addr.size() - ba); end
`ifdef SEQ_CHECKSUM_EN
        total++; if (q_ser.size() - bs != 1) begin bad++; $display("FAIL zero_words got %0d want 1", q_ser.size() - bs); end
        total++; if (q_ser[bs] !== 16'h0000) begin bad++; $display("FAIL zero_sum got %h want 0000", q_ser[bs]); end
`else
        total++; if (q_ser.size() != bs) begin bad++; $display("FAIL zero_words got %0d want 0", q_ser.size() - bs); end
        total++; if (q_done_cyc[bd] - t0 != 2) begin bad++; $display("FAIL zero_done_latency got %0d want 2", q_done_cyc[bd] - t0); end
`endif
        total++; if (n_done - bd != 1) begin bad++; $display("FAIL zero_done got %0d want 1", n_done - bd); end
    endtask

    task automatic test_wr_block;
        int ba, bs, bd, bo, t0;
        bit to;
        mem[0] = 16'hABCD;
        ser_len = 4;
        ba = q_addr.size(); bs = q_ser.size(); bd = n_done; bo = n_overlap;
        wr_active = 1'b1;
        send_frame(1, t0);
        repeat (12) @(negedge sysclk);
        total++; if (q_addr.size() != ba) begin bad++; $display("FAIL block_reads got %0d want 0", q_addr.size() - ba); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL block_busy got %b want 1", busy); end
        @(posedge sysclk); #1;
        wr_active = 1'b0;
        @(negedge sysclk);
        total++; if (rd_en !== 1'b1) begin bad++; $display("FAIL block_release_rd_en got %b want 1", rd_en); end
        total++; if (rd_addr !== '0) begin bad++; $display("FAIL block_release_addr got %h want 0", rd_addr); end
        wait_done(bd, 100, to);
        total++; if (to) begin bad++; $display("FAIL block_timeout got timeout want done"); end
        total++; if (q_ser[bs] !== 16'hABCD) begin bad++; $display("FAIL block_word got %h want abcd", q_ser[bs]); end
        total++; if (q_addr.size() - ba != 1) begin bad++; $display("FAIL block_read_count got %0d want 1", q_addr.size() - ba); end
        total++; if (n_overlap != bo) begin bad++; $display("FAIL block_overlap got %0d want 0", n_overlap - bo); end
    endtask

    task automatic test_full;
        int ba, bs, bd, t0, e_addr, e_ser;
        bit to;
        for (int i = 0; i < 256; i++) mem[i] = DW'(i);
        ser_len = 2;
        ba = q_addr.size(); bs = q_ser.size(); bd = n_done;
        send_frame(256, t0);
        wait_done(bd, 6000, to);
        total++; if (to) begin bad++; $display("FAIL full_timeout got timeout want done"); end
        repeat (3) @(negedge sysclk);
        total++; if (q_addr.size() - ba != 256) begin bad++; $display("FAIL full_reads got %0d want 256", q_addr.size() - ba); end
        total++; if (q_addr[q_addr.size()-1] !== 8'hFF) begin bad++; $display("FAIL full_last_addr got %h want ff", q_addr[q_addr.size()-1]); end
        e_addr = 0; e_ser = 0;
        for (int i = 0; i < 256; i++) begin
            if (q_addr[ba+i] !== AW'(i)) e_addr++;
            if (q_ser[bs+i] !== DW'(i)) e_ser++;
        end
        total++; if (e_addr != 0) begin bad++; $display("FAIL full_addr_seq got %0d wrong want 0", e_addr); end
        total++; if (e_ser != 0) begin bad++; $display("FAIL full_word_seq got %0d wrong want 0", e_ser); end
`ifdef SEQ_CHECKSUM_EN
        total++; if (q_ser.size() - bs != 257) begin bad++; $display("FAIL full_words got %0d want 257", q_ser.size() - bs); end
        total++; if (q_ser[bs+256] !== 16'h7F80) begin bad++; $display("FAIL full_sum got %h want 7f80", q_ser[bs+256]); end
`else
        total++; if (q_ser.size() - bs != 256) begin bad++; $display("FAIL full_words got %0d want 256", q_ser.size() - bs); end
`endif
        total++; if (n_done - bd != 1) begin bad++; $display("FAIL full_done got %0d want 1", n_done - bd); end
    endtask

    task automatic test_mid_reset;
        int ba, bs, bd, t0, k;
        bit to;
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        ser_len = 20;
        send_frame(3, t0);
        k = 0;
        while (ser_busy !== 1'b1 && k < 60) begin
            @(negedge sysclk);
            k++;
        end
        total++; if (ser_busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_seen got %b want 1", ser_busy); end
        repeat (3) @(negedge sysclk);
        #1 reset = 1'b0;
        #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        total++; if (ser_data !== '0)    begin bad++; $display("FAIL midrst_ser_data got %h want 0", ser_data); end
        total++; if (rd_addr !== '0)     begin bad++; $display("FAIL midrst_rd_addr got %h want 0", rd_addr); end
        total++; if ((rd_en | ser_start | done) !== 1'b0) begin bad++; $display("FAIL midrst_strobes got %b%b%b want 000", rd_en, ser_start, done); end
        @(posedge sysclk); #1;
        reset = 1'b1;
        repeat (3) @(posedge sysclk);
        ba = q_addr.size(); bs = q_ser.size(); bd = n_done;
        send_frame(2, t0);
        wait_done(bd, 300, to);
        total++; if (to) begin bad++; $display("FAIL restart_timeout got timeout want done"); end
        total++; if (q_addr[ba] !== 8'h00) begin bad++; $display("FAIL restart_addr got %h want 00", q_addr[ba]); end
        total++; if (q_ser[bs] !== 16'h1111) begin bad++; $display("FAIL restart_word0 got %h want 1111", q_ser[bs]); end
        total++; if (q_ser[bs+1] !== 16'h2222) begin bad++; $display("FAIL restart_word1 got %h want 2222", q_ser[bs+1]); end
`ifdef SEQ_CHECKSUM_EN
        total++; if (q_ser[bs+2] !== 16'h3333) begin bad++; $display("FAIL restart_sum got %h want 3333", q_ser[bs+2]); end
`endif
        total++; if (n_done - bd != 1) begin bad++; $display("FAIL restart_done got %0d want 1", n_done - bd); end
    endtask

`ifdef SEQ_CHECKSUM_EN
    task automatic test_checksum;
        int bs, bd, t0;
        bit to;
        mem[0] = 16'hFFFF; mem[1] = 16'h0002;
        ser_len = 3;
        bs = q_ser.size(); bd = n_done;
        send_frame(2, t0);
        wait_done(bd, 200, to);
        total++; if (to) begin bad++; $display("FAIL csum_timeout got timeout want done"); end
        total++; if (q_ser.size() - bs != 3) begin bad++; $display("FAIL csum_words got %0d want 3", q_ser.size() - bs); end
        total++; if (q_ser[bs+2] !== 16'h0001) begin bad++; $display("FAIL csum_value got %h want 0001", q_ser[bs+2]); end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_zero;
        test_wr_block;
        test_full;
        test_mid_reset;
`ifdef SEQ_CHECKSUM_EN
        test_checksum;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
